// File: rtl/portal_ind_arbiter.sv
// portal_ind_arbiter
//   Shares one portal indication channel among NUM_SRC indication FIFOs.
//   Round-robin arbitration happens per message. Once a source is granted,
//   every word of its current message is forwarded before another source is
//   considered. Each message is followed by at least one IDLE cycle.
//
// Ports
//   CLK, RST            clock; asynchronous active-high reset
//   src_notEmpty        per-source "head word available"
//   src_first           per-source head word, source i at [i*DATA_W +: DATA_W]
//   src_len             per-source message word count, sampled at grant (0 => 1)
//   src_deq             one-hot pop strobe to the granted source
//   RDY_ind_first/ind_first, RDY_ind_notEmpty/ind_notEmpty,
//   RDY_ind_deq/EN_ind_deq   consumer-side portal indication interface
//   RDY_intr_status/intr_status    OR of all source requests
//   RDY_intr_channel/intr_channel  granted, about-to-be-granted or last source
//   err_deq             sticky flag: consumer popped while nothing was ready
module portal_ind_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_SRC-1:0]        src_notEmpty,
  input  logic [NUM_SRC*DATA_W-1:0] src_first,
  input  logic [NUM_SRC*LEN_W-1:0]  src_len,
  output logic [NUM_SRC-1:0]        src_deq,
  output logic                      RDY_ind_first,
  output logic [DATA_W-1:0]         ind_first,
  output logic                      RDY_ind_notEmpty,
  output logic                      ind_notEmpty,
  output logic                      RDY_ind_deq,
  input  logic                      EN_ind_deq,
  output logic                      RDY_intr_status,
  output logic                      intr_status,
  output logic                      RDY_intr_channel,
  output logic [31:0]               intr_channel,
  output logic                      err_deq
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   grant, last, cand, chan;
  logic               cand_vld;
  logic [LEN_W-1:0]   remain, cand_len;
  logic               head_vld, pop;

  // Round-robin search starting just after the last granted source.
  always_comb begin
    cand     = last;
    cand_vld = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!cand_vld && src_notEmpty[(int'(last) + k) % NUM_SRC]) begin
        cand_vld = 1'b1;
        cand     = IDX_W'((int'(last) + k) % NUM_SRC);
      end
    end
  end

  assign cand_len = src_len[int'(cand)*LEN_W +: LEN_W];
  assign head_vld = src_notEmpty[grant];
  assign pop      = (state == BUSY) && EN_ind_deq && head_vld;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    src_deq      = '0;
    ind_notEmpty = 1'b0;
    ind_first    = '0;
    chan         = last;
    case (state)
      IDLE: begin
        if (cand_vld) begin
          state_nxt = BUSY;
          chan      = cand;
        end
      end
      BUSY: begin
        // A source that runs dry mid-message stalls the channel; grant holds.
        ind_notEmpty = head_vld;
        ind_first    = src_first[int'(grant)*DATA_W +: DATA_W];
        chan         = grant;
        if (pop) begin
          src_deq[grant] = 1'b1;
          if (remain == LEN_W'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      grant   <= '0;
      last    <= IDX_W'(NUM_SRC - 1);
      remain  <= '0;
      err_deq <= 1'b0;
    end else begin
      if (state == IDLE && cand_vld) begin
        grant  <= cand;
        // A zero-length header still carries one word.
        remain <= (cand_len == '0) ? LEN_W'(1) : cand_len;
      end
      if (pop && remain != '0) remain <= remain - LEN_W'(1);
      if (pop && remain == LEN_W'(1)) last <= grant;
      if (EN_ind_deq && !ind_notEmpty) err_deq <= 1'b1;
    end
  end

  assign RDY_ind_first    = ind_notEmpty;
  assign RDY_ind_deq      = ind_notEmpty;
  assign RDY_ind_notEmpty = 1'b1;
  assign RDY_intr_status  = 1'b1;
  assign RDY_intr_channel = 1'b1;
  assign intr_status      = |src_notEmpty;
  assign intr_channel     = 32'(chan);

endmodule

// File: tb/tb_portal_ind_arbiter.sv
// Directed testbench for portal_ind_arbiter (NUM_SRC=4, DATA_W=32, LEN_W=8).
// Each source is modelled as a word queue; src_len is driven from len_r.
module tb_portal_ind_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   src_notEmpty;
  logic [127:0] src_first;
  logic [31:0]  src_len;
  logic [3:0]   src_deq;
  logic         RDY_ind_first, RDY_ind_notEmpty, ind_notEmpty, RDY_ind_deq;
  logic [31:0]  ind_first;
  logic         EN_ind_deq = 1'b0;
  logic         RDY_intr_status, intr_status, RDY_intr_channel;
  logic [31:0]  intr_channel;
  logic         err_deq;

  logic [31:0]  q [4][$];
  logic [7:0]   len_r [4];
  int           checks = 0;
  int           fails  = 0;

  portal_ind_arbiter #(.NUM_SRC(4), .DATA_W(32), .LEN_W(8)) dut (
    .CLK(clk), .RST(rst),
    .src_notEmpty(src_notEmpty), .src_first(src_first), .src_len(src_len),
    .src_deq(src_deq),
    .RDY_ind_first(RDY_ind_first), .ind_first(ind_first),
    .RDY_ind_notEmpty(RDY_ind_notEmpty), .ind_notEmpty(ind_notEmpty),
    .RDY_ind_deq(RDY_ind_deq), .EN_ind_deq(EN_ind_deq),
    .RDY_intr_status(RDY_intr_status), .intr_status(intr_status),
    .RDY_intr_channel(RDY_intr_channel), .intr_channel(intr_channel),
    .err_deq(err_deq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_srcs();
    for (int i = 0; i < 4; i++) begin
      src_notEmpty[i]      = (q[i].size() != 0);
      src_first[i*32 +: 32] = (q[i].size() != 0) ? q[i][0] : 32'h0;
      src_len[i*8 +: 8]    = len_r[i];
    end
  endtask

  // Called at the negative edge: latch the pop strobes, cross the active
  // edge, then apply the pops to the source queues.
  task automatic adv();
    logic [3:0]  d;
    logic [31:0] tmp;
    d = src_deq;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (d[i]) begin
        checks++;
        if (q[i].size() == 0) begin
          fails++;
          $display("FAIL deq_on_empty src%0d: popped with 0 words, required none", i);
        end else tmp = q[i].pop_front();
      end
    end
    drive_srcs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    EN_ind_deq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      len_r[i] = 8'd0;
    end
    drive_srcs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) len_r[i] = 8'd0;
    drive_srcs();
    @(posedge clk);
    @(negedge clk);
    checks++; if (src_deq !== 4'b0) begin fails++; $display("FAIL rst_deq got %b want 0000", src_deq); end
    checks++; if (ind_notEmpty !== 1'b0) begin fails++; $display("FAIL rst_notEmpty got %b want 0", ind_notEmpty); end
    checks++; if (RDY_ind_first !== 1'b0 || RDY_ind_deq !== 1'b0) begin fails++; $display("FAIL rst_rdy got %b%b want 00", RDY_ind_first, RDY_ind_deq); end
    checks++; if (ind_first !== 32'h0) begin fails++; $display("FAIL rst_first got %h want 0", ind_first); end
    checks++; if (err_deq !== 1'b0) begin fails++; $display("FAIL rst_err got %b want 0", err_deq); end
    checks++; if (intr_channel !== 32'd3) begin fails++; $display("FAIL rst_chan got %0d want 3", intr_channel); end
    checks++; if (intr_status !== 1'b0) begin fails++; $display("FAIL rst_status got %b want 0", intr_status); end
    checks++; if ({RDY_ind_notEmpty, RDY_intr_status, RDY_intr_channel} !== 3'b111) begin
      fails++; $display("FAIL rst_const_rdy got %b want 111", {RDY_ind_notEmpty, RDY_intr_status, RDY_intr_channel});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic_grant();
    logic [31:0] w [3];
    w[0] = 32'hAAAA_0001; w[1] = 32'hBBBB_0002; w[2] = 32'hCCCC_0003;
    do_reset();
    for (int k = 0; k < 3; k++) q[2].push_back(w[k]);
    len_r[2] = 8'd3;
    drive_srcs();
    @(negedge clk);
    checks++; if (intr_channel !== 32'd2) begin fails++; $display("FAIL basic_cand got %0d want 2", intr_channel); end
    checks++; if (ind_notEmpty !== 1'b0 || src_deq !== 4'b0) begin fails++; $display("FAIL basic_bubble got ne=%b deq=%b want 0 0000", ind_notEmpty, src_deq); end
    checks++; if (intr_status !== 1'b1) begin fails++; $display("FAIL basic_status got %b want 1", intr_status); end
    adv();
    for (int k = 0; k < 3; k++) begin
      EN_ind_deq = 1'b1;
      @(negedge clk);
      checks++; if (ind_first !== w[k]) begin fails++; $display("FAIL basic_word%0d got %h want %h", k, ind_first, w[k]); end
      checks++; if (src_deq !== 4'b0100) begin fails++; $display("FAIL basic_deq%0d got %b want 0100", k, src_deq); end
      checks++; if (intr_channel !== 32'd2 || ind_notEmpty !== 1'b1) begin fails++; $display("FAIL basic_busy%0d got ch=%0d ne=%b want 2 1", k, intr_channel, ind_notEmpty); end
      adv();
    end
    EN_ind_deq = 1'b0;
    @(negedge clk);
    checks++; if (ind_notEmpty !== 1'b0 || src_deq !== 4'b0) begin fails++; $display("FAIL basic_idle got ne=%b deq=%b want 0 0000", ind_notEmpty, src_deq); end
    checks++; if (intr_channel !== 32'd2) begin fails++; $display("FAIL basic_last got %0d want 2", intr_channel); end
    checks++; if (err_deq !== 1'b0) begin fails++; $display("FAIL basic_err got %b want 0", err_deq); end
  endtask

  task automatic test_fairness();
    int order [6];
    order = '{0, 1, 3, 0, 1, 3};
    do_reset();
    foreach (order[m]) if (m < 3) begin
      q[order[m]].push_back(32'h100 * order[m] + 0);
      q[order[m]].push_back(32'h100 * order[m] + 1);
      len_r[order[m]] = 8'd1;
    end
    drive_srcs();
    for (int m = 0; m < 6; m++) begin
      EN_ind_deq = 1'b0;
      @(negedge clk);
      checks++; if (ind_notEmpty !== 1'b0 || intr_channel !== 32'(order[m])) begin
        fails++; $display("FAIL fair_idle%0d got ne=%b ch=%0d want 0 %0d", m, ind_notEmpty, intr_channel, order[m]);
      end
      adv();
      EN_ind_deq = 1'b1;
      @(negedge clk);
      checks++; if (src_deq !== 4'(1 << order[m])) begin fails++; $display("FAIL fair_deq%0d got %b want src %0d", m, src_deq, order[m]); end
      checks++; if (ind_first !== 32'h100 * order[m] + 32'(m / 3)) begin fails++; $display("FAIL fair_word%0d got %h", m, ind_first); end
      adv();
    end
    EN_ind_deq = 1'b0;
    @(negedge clk);
    checks++; if (intr_status !== 1'b0 || ind_notEmpty !== 1'b0) begin fails++; $display("FAIL fair_end got st=%b ne=%b want 0 0", intr_status, ind_notEmpty); end
  endtask

  task automatic test_atomicity();
    do_reset();
    q[1].push_back(32'h1111_0001); q[1].push_back(32'h1111_0002);
    len_r[1] = 8'd4;
    drive_srcs();
    @(negedge clk);
    checks++; if (intr_channel !== 32'd1) begin fails++; $display("FAIL atom_cand got %0d want 1", intr_channel); end
    adv();
    q[0].push_back(32'h0000_00F0);
    len_r[0] = 8'd1;
    drive_srcs();
    for (int k = 0; k < 2; k++) begin
      EN_ind_deq = 1'b1;
      @(negedge clk);
      checks++; if (src_deq !== 4'b0010 || ind_first !== 32'h1111_0001 + 32'(k)) begin
        fails++; $display("FAIL atom_pre%0d got deq=%b word=%h want 0010 %h", k, src_deq, ind_first, 32'h1111_0001 + 32'(k));
      end
      adv();
    end
    EN_ind_deq = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (ind_notEmpty !== 1'b0 || intr_channel !== 32'd1 || src_deq !== 4'b0) begin
        fails++; $display("FAIL atom_stall%0d got ne=%b ch=%0d deq=%b want 0 1 0000", k, ind_notEmpty, intr_channel, src_deq);
      end
      adv();
    end
    q[1].push_back(32'h1111_0003); q[1].push_back(32'h1111_0004);
    drive_srcs();
    for (int k = 2; k < 4; k++) begin
      EN_ind_deq = 1'b1;
      @(negedge clk);
      checks++; if (src_deq !== 4'b0010 || ind_first !== 32'h1111_0001 + 32'(k)) begin
        fails++; $display("FAIL atom_post%0d got deq=%b word=%h want 0010 %h", k, src_deq, ind_first, 32'h1111_0001 + 32'(k));
      end
      adv();
    end
    EN_ind_deq = 1'b0;
    @(negedge clk);
    checks++; if (ind_notEmpty !== 1'b0 || intr_channel !== 32'd0) begin fails++; $display("FAIL atom_next got ne=%b ch=%0d want 0 0", ind_notEmpty, intr_channel); end
    adv();
    EN_ind_deq = 1'b1;
    @(negedge clk);
    checks++; if (src_deq !== 4'b0001 || ind_first !== 32'h0000_00F0) begin fails++; $display("FAIL atom_src0 got deq=%b word=%h want 0001 000000f0", src_deq, ind_first); end
    adv();
    EN_ind_deq = 1'b0;
    @(negedge clk);
    checks++; if (err_deq !== 1'b0) begin fails++; $display("FAIL atom_err got %b want 0", err_deq); end
  endtask

  task automatic test_zero_len();
    do_reset();
    q[0].push_back(32'h5A5A_0000); q[0].push_back(32'h5A5A_0001);
    len_r[0] = 8'd0;
    drive_srcs();
    @(negedge clk);
    adv();
    EN_ind_deq = 1'b1;
    @(negedge clk);
    checks++; if (src_deq !== 4'b0001 || ind_first !== 32'h5A5A_0000) begin fails++; $display("FAIL zlen_word got deq=%b word=%h want 0001 5a5a0000", src_deq, ind_first); end
    adv();
    EN_ind_deq = 1'b0;
    @(negedge clk);
    checks++; if (ind_notEmpty !== 1'b0 || src_deq !== 4'b0 || intr_channel !== 32'd0) begin
      fails++; $display("FAIL zlen_idle got ne=%b deq=%b ch=%0d want 0 0000 0", ind_notEmpty, src_deq, intr_channel);
    end
    q[0].delete();
    drive_srcs();
  endtask

  task automatic test_bad_deq();
    do_reset();
    EN_ind_deq = 1'b1;
    @(negedge clk);
    checks++; if (src_deq !== 4'b0 || err_deq !== 1'b0) begin fails++; $display("FAIL bad_pulse got deq=%b err=%b want 0000 0", src_deq, err_deq); end
    adv();
    EN_ind_deq = 1'b0;
    @(negedge clk);
    checks++; if (err_deq !== 1'b1) begin fails++; $display("FAIL bad_set got %b want 1", err_deq); end
    q[2].push_back(32'h6666_0001);
    len_r[2] = 8'd1;
    adv();
    @(negedge clk);
    adv();
    EN_ind_deq = 1'b1;
    @(negedge clk);
    checks++; if (src_deq !== 4'b0100 || ind_first !== 32'h6666_0001) begin fails++; $display("FAIL bad_good got deq=%b word=%h want 0100 66660001", src_deq, ind_first); end
    adv();
    EN_ind_deq = 1'b0;
    @(negedge clk);
    checks++; if (err_deq !== 1'b1) begin fails++; $display("FAIL bad_sticky got %b want 1", err_deq); end
    rst = 1'b1;
    #1;
    checks++; if (err_deq !== 1'b0) begin fails++; $display("FAIL bad_clear got %b want 0", err_deq); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    q[3].push_back(32'h3333_0000); q[3].push_back(32'h3333_0001); q[3].push_back(32'h3333_0002);
    len_r[3] = 8'd3;
    drive_srcs();
    @(negedge clk);
    adv();
    EN_ind_deq = 1'b1;
    @(negedge clk);
    checks++; if (src_deq !== 4'b1000 || ind_first !== 32'h3333_0000) begin fails++; $display("FAIL rmid_w0 got deq=%b word=%h want 1000 33330000", src_deq, ind_first); end
    adv();
    q[0].push_back(32'h0000_0ABC);
    len_r[0] = 8'd1;
    drive_srcs();
    @(negedge clk);
    checks++; if (src_deq !== 4'b1000 || ind_notEmpty !== 1'b1) begin fails++; $display("FAIL rmid_pre got deq=%b ne=%b want 1000 1", src_deq, ind_notEmpty); end
    rst = 1'b1;
    #1;
    checks++; if (src_deq !== 4'b0 || ind_notEmpty !== 1'b0 || ind_first !== 32'h0) begin
      fails++; $display("FAIL rmid_async got deq=%b ne=%b word=%h want 0000 0 0", src_deq, ind_notEmpty, ind_first);
    end
    checks++; if (RDY_ind_first !== 1'b0 || RDY_ind_deq !== 1'b0 || intr_channel !== 32'd0) begin
      fails++; $display("FAIL rmid_rdy got rf=%b rd=%b ch=%0d want 0 0 0", RDY_ind_first, RDY_ind_deq, intr_channel);
    end
    EN_ind_deq = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    len_r[3] = 8'd2;
    drive_srcs();
    @(negedge clk);
    checks++; if (intr_channel !== 32'd0) begin fails++; $display("FAIL rmid_prio got %0d want 0", intr_channel); end
    adv();
    EN_ind_deq = 1'b1;
    @(negedge clk);
    checks++; if (src_deq !== 4'b0001 || ind_first !== 32'h0000_0ABC) begin fails++; $display("FAIL rmid_src0 got deq=%b word=%h want 0001 00000abc", src_deq, ind_first); end
    adv();
    EN_ind_deq = 1'b0;
    @(negedge clk);
    checks++; if (intr_channel !== 32'd3) begin fails++; $display("FAIL rmid_next got %0d want 3", intr_channel); end
    adv();
    for (int k = 1; k < 3; k++) begin
      EN_ind_deq = 1'b1;
      @(negedge clk);
      checks++; if (src_deq !== 4'b1000 || ind_first !== 32'h3333_0000 + 32'(k)) begin
        fails++; $display("FAIL rmid_rest%0d got deq=%b word=%h want 1000 %h", k, src_deq, ind_first, 32'h3333_0000 + 32'(k));
      end
      adv();
    end
    EN_ind_deq = 1'b0;
    @(negedge clk);
    checks++; if (ind_notEmpty !== 1'b0 || intr_status !== 1'b0) begin fails++; $display("FAIL rmid_end got ne=%b st=%b want 0 0", ind_notEmpty, intr_status); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) len_r[i] = 8'd0;
    drive_srcs();
    test_reset();
    test_basic_grant();
    test_fairness();
    test_atomicity();
    test_zero_len();
    test_bad_deq();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
